// File: rtl/nonce_range_supervisor_if.sv
// Miner-array bus: supervisor-side control/nonces out, per-miner completion and hashes back.
interface nonce_range_supervisor_if #(
  parameter int NUM_MINERS = 4
);
  logic                        miner_clear;
  logic                        miner_start;
  logic [32*NUM_MINERS-1:0]    miner_nonce;
  logic [NUM_MINERS-1:0]       miner_active;
  logic [NUM_MINERS-1:0]       miner_done;
  logic [256*NUM_MINERS-1:0]   miner_hash;

  modport master (
    output miner_clear, miner_start, miner_nonce, miner_active,
    input  miner_done, miner_hash
  );

  modport slave (
    input  miner_clear, miner_start, miner_nonce, miner_active,
    output miner_done, miner_hash
  );
endinterface

// File: rtl/nonce_range_supervisor.sv
// Nonce range supervisor: sweeps [nonce_start, nonce_end] across NUM_MINERS
// interleaved miner cores, scans each round's results in ascending nonce
// order and reports the first hash meeting the leading-zero target.
module nonce_range_supervisor #(
  parameter int NUM_MINERS = 4,
  parameter int IDX_W      = (NUM_MINERS > 1) ? $clog2(NUM_MINERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              nonce_start,
  input  logic [31:0]              nonce_end,
  input  logic [8:0]               target_zeros,
  nonce_range_supervisor_if.master miners,
  output logic                     busy,
  output logic                     done,
  output logic                     success,
  output logic                     aborted,
  output logic [31:0]              nonce_out,
  output logic [255:0]             hash_out,
  output logic [31:0]              rounds
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]          base_q;
  logic [31:0]          end_q;
  logic [8:0]           tz_q;
  logic [IDX_W-1:0]     idx_q;
  logic [255:0]         hash_q [NUM_MINERS];

  logic [NUM_MINERS-1:0]     active;
  logic [32*NUM_MINERS-1:0]  nonce_vec;
  logic                      all_done;
  logic [255:0]              cur_hash;
  logic                      hit;
  logic                      last_idx;
  logic                      final_round;
  logic                      range_bad;

  // Leading zeros from bit 255 downwards; an all-zero hash counts 256.
  function automatic logic [8:0] lzc(input logic [255:0] h);
    logic [8:0] n;
    logic       seen;
    n    = '0;
    seen = 1'b0;
    for (int unsigned b = 0; b < 256; b++) begin
      if (!seen && !h[255-b]) n = n + 9'd1;
      else                    seen = 1'b1;
    end
    return n;
  endfunction

  // Per-slice nonce and activity; 33-bit compare keeps slices past 0xFFFF_FFFF inactive.
  always_comb begin
    active    = '0;
    nonce_vec = '0;
    for (int unsigned i = 0; i < NUM_MINERS; i++) begin
      active[i]            = ({1'b0, base_q} + 33'(i)) <= {1'b0, end_q};
      nonce_vec[i*32 +: 32] = base_q + 32'(i);
    end
  end

  // Round bookkeeping: completion, scan hit, last index, final-round and empty-range tests.
  always_comb begin
    all_done    = ((miners.miner_done & active) == active);
    cur_hash    = hash_q[idx_q];
    hit         = active[idx_q] && (lzc(cur_hash) >= tz_q);
    last_idx    = (idx_q == IDX_W'(NUM_MINERS - 1));
    final_round = ({1'b0, base_q} + 33'(NUM_MINERS - 1)) >= {1'b0, end_q};
    range_bad   = (nonce_end < nonce_start);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs; abort outranks a same-cycle hit.
  always_comb begin
    state_d             = state_q;
    busy                = 1'b0;
    done                = 1'b0;
    miners.miner_clear  = 1'b0;
    miners.miner_start  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) state_d = range_bad ? S_DONE : S_LAUNCH;
      end
      S_LAUNCH: begin
        busy               = 1'b1;
        miners.miner_clear = 1'b1;
        state_d            = abort ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        busy               = 1'b1;
        miners.miner_start = 1'b1;
        if (abort)         state_d = S_DONE;
        else if (all_done) state_d = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (abort || hit)  state_d = S_DONE;
        else if (last_idx) state_d = final_round ? S_DONE : S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Miner bus outputs are only meaningful while a run is active.
  always_comb begin
    miners.miner_active = busy ? active    : '0;
    miners.miner_nonce  = busy ? nonce_vec : '0;
  end

  // Datapath: config latch, hash capture, scan index, result and round counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      end_q     <= '0;
      tz_q      <= '0;
      idx_q     <= '0;
      success   <= 1'b0;
      aborted   <= 1'b0;
      nonce_out <= '0;
      hash_out  <= '0;
      rounds    <= '0;
      for (int unsigned i = 0; i < NUM_MINERS; i++) hash_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q    <= nonce_start;
            end_q     <= nonce_end;
            tz_q      <= target_zeros;
            success   <= 1'b0;
            aborted   <= 1'b0;
            nonce_out <= '0;
            hash_out  <= '0;
            rounds    <= '0;
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            aborted   <= 1'b1;
            nonce_out <= base_q;
          end
        end
        S_WAIT: begin
          if (abort) begin
            aborted   <= 1'b1;
            nonce_out <= base_q;
          end else if (all_done) begin
            for (int unsigned i = 0; i < NUM_MINERS; i++)
              hash_q[i] <= miners.miner_hash[i*256 +: 256];
            idx_q <= '0;
          end
        end
        S_SCAN: begin
          if (abort) begin
            aborted   <= 1'b1;
            nonce_out <= base_q;
          end else if (hit) begin
            success   <= 1'b1;
            nonce_out <= base_q + 32'(idx_q);
            hash_out  <= cur_hash;
          end else begin
            idx_q <= idx_q + 1'b1;
            if (last_idx) begin
              if (rounds != '1) rounds <= rounds + 32'd1;
              if (final_round) nonce_out <= base_q;
              else             base_q    <= base_q + 32'(NUM_MINERS);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
